// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional-unit
// producers, one registered broadcast per cycle, flush drains all pending
// results, and a saturating broadcast counter.

package cdb_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  dest_ROB_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        from_memory;
  } CDB_packet_t;

endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] fu_valid,
  input  CDB_packet_t          fu_pkt [NUM_UNITS],
  input  logic                 flush,
  output logic [NUM_UNITS-1:0] fu_yumi,
  output logic                 cdb_valid,
  output CDB_packet_t          cdb_pkt,
  output logic [15:0]          bcast_count
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_UNITS - 1);

  logic [PTR_W-1:0] ptr_r;
  logic             cdb_valid_r;
  CDB_packet_t      cdb_pkt_r;
  logic [15:0]      bcast_count_r;

  logic             grant_valid_s;
  logic [PTR_W-1:0] grant_idx_s;

  // Round-robin search: first valid unit at or after start, wrapping past
  // the last unit. Returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_UNITS-1:0] valid,
                                             input logic [PTR_W-1:0]     start);
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] cand_idx;
    int unsigned      cand;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      cand = int'(start) + off;
      if (cand >= NUM_UNITS) begin
        cand = cand - NUM_UNITS;
      end else begin
        cand = cand;
      end
      cand_idx = cand[PTR_W-1:0];
      if (!found && valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Pick the unit that wins the bus this cycle.
  always_comb begin
    {grant_valid_s, grant_idx_s} = rr_pick(fu_valid, ptr_r);
  end

  // Consume strobes: nothing in reset, drain everything on flush, else one-hot grant.
  always_comb begin
    fu_yumi = '0;
    if (reset) begin
      fu_yumi = '0;
    end else if (flush) begin
      fu_yumi = fu_valid;
    end else if (grant_valid_s) begin
      fu_yumi[grant_idx_s] = 1'b1;
    end else begin
      fu_yumi = '0;
    end
  end

  // Broadcast register, round-robin pointer and saturating broadcast counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid_r   <= 1'b0;
      cdb_pkt_r     <= '0;
      ptr_r         <= '0;
      bcast_count_r <= 16'd0;
    end else if (flush) begin
      // Packet register holds; only the valid is dropped.
      cdb_valid_r   <= 1'b0;
      ptr_r         <= '0;
    end else if (grant_valid_s) begin
      cdb_valid_r <= 1'b1;
      cdb_pkt_r   <= fu_pkt[grant_idx_s];
      if (grant_idx_s == LAST_IDX) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= grant_idx_s + PTR_W'(1);
      end
      if (bcast_count_r != 16'hFFFF) begin
        bcast_count_r <= bcast_count_r + 16'd1;
      end else begin
        bcast_count_r <= bcast_count_r;
      end
    end else begin
      cdb_valid_r <= 1'b0;
    end
  end

  assign cdb_valid   = cdb_valid_r;
  assign cdb_pkt     = cdb_pkt_r;
  assign bcast_count = bcast_count_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with hand-computed expectations.

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  fu_valid;
  CDB_packet_t fu_pkt [4];
  logic        flush;
  logic [3:0]  fu_yumi;
  logic        cdb_valid;
  CDB_packet_t cdb_pkt;
  logic [15:0] bcast_count;

  CDB_packet_t exp_pkt [4];
  CDB_packet_t beef_pkt;
  int          n_checks;
  int          n_fail;

  cdb_arbiter #(.NUM_UNITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_pkt      (fu_pkt),
    .flush       (flush),
    .fu_yumi     (fu_yumi),
    .cdb_valid   (cdb_valid),
    .cdb_pkt     (cdb_pkt),
    .bcast_count (bcast_count)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    fu_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fu_pkt[i] = '0;
      exp_pkt[i].dest_ROB_entry = 4'(i + 1);
      exp_pkt[i].result         = 32'h1000_0000 + 32'(i);
      exp_pkt[i].branch_result  = (i == 1 || i == 3) ? 1'b1 : 1'b0;
      exp_pkt[i].from_memory    = (i >= 2) ? 1'b1 : 1'b0;
    end
    tick();
    tick();

    // Reset beats flush and requests.
    fu_valid = 4'b1111;
    flush    = 1'b1;
    #1;
    check_eq("yumi_in_reset", 64'(fu_yumi), 64'h0);
    tick();
    reset    = 1'b0;
    flush    = 1'b0;
    fu_valid = 4'b0000;
    #1;
    check_eq("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check_eq("rst_cdb_pkt", 64'(cdb_pkt), 64'h0);
    check_eq("rst_count", 64'(bcast_count), 64'h0);
    check_eq("rst_ptr", 64'(dut.ptr_r), 64'h0);

    // Single producer on unit 2.
    beef_pkt.dest_ROB_entry = 4'd5;
    beef_pkt.result         = 32'hDEAD_BEEF;
    beef_pkt.branch_result  = 1'b0;
    beef_pkt.from_memory    = 1'b0;
    fu_pkt[2] = beef_pkt;
    fu_valid  = 4'b0100;
    #1;
    check_eq("single_yumi", 64'(fu_yumi), 64'h4);
    tick();
    fu_valid = 4'b0000;
    check_eq("single_valid", 64'(cdb_valid), 64'h1);
    check_eq("single_pkt", 64'(cdb_pkt), 64'(beef_pkt));
    check_eq("single_count", 64'(bcast_count), 64'h1);
    check_eq("single_ptr", 64'(dut.ptr_r), 64'h3);

    // Flush while a broadcast is on the bus.
    fu_valid = 4'b1011;
    flush    = 1'b1;
    #1;
    check_eq("flush_yumi", 64'(fu_yumi), 64'hB);
    check_eq("flush_cur_valid", 64'(cdb_valid), 64'h1);
    tick();
    flush    = 1'b0;
    fu_valid = 4'b0000;
    check_eq("flush_next_valid", 64'(cdb_valid), 64'h0);
    check_eq("flush_ptr", 64'(dut.ptr_r), 64'h0);
    check_eq("flush_count", 64'(bcast_count), 64'h1);

    // Fairness: all units requesting from ptr=0.
    for (int i = 0; i < 4; i++) fu_pkt[i] = exp_pkt[i];
    fu_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq($sformatf("rr_yumi_%0d", k), 64'(fu_yumi), 64'(4'b0001 << (k % 4)));
      tick();
      check_eq($sformatf("rr_valid_%0d", k), 64'(cdb_valid), 64'h1);
      check_eq($sformatf("rr_pkt_%0d", k), 64'(cdb_pkt), 64'(exp_pkt[k % 4]));
    end
    fu_valid = 4'b0000;
    tick();
    check_eq("rr_idle_valid", 64'(cdb_valid), 64'h0);
    check_eq("rr_count", 64'(bcast_count), 64'd9);
    check_eq("rr_ptr", 64'(dut.ptr_r), 64'h0);

    // Wrap: move ptr to 3 via a grant to unit 2, then request 3 and 0.
    fu_valid = 4'b0100;
    tick();
    fu_valid = 4'b1001;
    check_eq("wrap_ptr_start", 64'(dut.ptr_r), 64'h3);
    #1;
    check_eq("wrap_yumi_first", 64'(fu_yumi), 64'h8);
    tick();
    check_eq("wrap_pkt_first", 64'(cdb_pkt), 64'(exp_pkt[3]));
    check_eq("wrap_ptr_mid", 64'(dut.ptr_r), 64'h0);
    fu_valid = 4'b0001;
    #1;
    check_eq("wrap_yumi_second", 64'(fu_yumi), 64'h1);
    tick();
    fu_valid = 4'b0000;
    check_eq("wrap_pkt_second", 64'(cdb_pkt), 64'(exp_pkt[0]));
    check_eq("wrap_ptr_end", 64'(dut.ptr_r), 64'h1);
    check_eq("wrap_count", 64'(bcast_count), 64'd12);

    // Reset in a cycle where a grant would happen.
    fu_valid = 4'b1111;
    reset    = 1'b1;
    #1;
    check_eq("midrst_yumi", 64'(fu_yumi), 64'h0);
    tick();
    reset = 1'b0;
    check_eq("midrst_valid", 64'(cdb_valid), 64'h0);
    check_eq("midrst_count", 64'(bcast_count), 64'h0);
    check_eq("midrst_ptr", 64'(dut.ptr_r), 64'h0);

    // Saturation: fu_valid stays high, one broadcast per cycle.
    repeat (65535) @(posedge clk);
    #1;
    check_eq("sat_reach", 64'(bcast_count), 64'hFFFF);
    tick();
    tick();
    check_eq("sat_hold", 64'(bcast_count), 64'hFFFF);
    check_eq("sat_valid", 64'(cdb_valid), 64'h1);
    fu_valid = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
